layer_compositor: RTL and testbench

//  Pipelined N-layer pixel compositor for the VGA path. Sits between the sprite/ROM

---
 rtl/layer_compositor_pkg.sv | 17 +
 rtl/layer_compositor_if.sv | 29 ++
 rtl/layer_compositor_fade.sv | 88 ++++++++
 rtl/layer_compositor.sv | 96 +++++++++
 tb/tb_layer_compositor.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared pixel/fade types and the 4-bit colour scaler used by the compositor.
package vga_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} fade_state_e;

    localparam logic [4:0] LEVEL_MAX = 5'd16;

    // (c4 * level) >> 4 as a 9-bit product; level 16 is an exact pass-through.
    function automatic logic [3:0] scale4(input logic [3:0] c4, input logic [4:0] level);
        logic [8:0] prod;
        prod = {5'd0, c4} * {4'd0, level};
        return prod[7:4];
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-source, fade-control and DAC-side signals of the layer compositor.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 6,
    parameter int NUM_OVL    = 2
);
    logic                     frame_start;
    logic                     de_in;
    logic [NUM_LAYERS-1:0]    layer_en;
    logic [NUM_LAYERS*16-1:0] layer_data;
    logic [NUM_OVL-1:0]       ovl_en;
    logic [NUM_OVL*16-1:0]    ovl_color;
    logic                     fade_req;
    logic [3:0]               red_port;
    logic [3:0]               green_port;
    logic [3:0]               blue_port;
    logic                     de_out;
    logic                     fade_busy;
    logic                     fade_black;

    modport master (
        output frame_start, de_in, layer_en, layer_data, ovl_en, ovl_color, fade_req,
        input  red_port, green_port, blue_port, de_out, fade_busy, fade_black
    );

    modport slave (
        input  frame_start, de_in, layer_en, layer_data, ovl_en, ovl_color, fade_req,
        output red_port, green_port, blue_port, de_out, fade_busy, fade_black
    );
endinterface

// File: rtl/layer_compositor_fade.sv
// Frame-synchronous fade-out / hold / fade-in sequencer; o_level is the level
// that pixels leaving the output stage on this cycle must use.
module fade_sequencer
    import vga_pkg::*;
#(
    parameter int FADE_STEP   = 2,
    parameter int HOLD_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_frame_start,
    input  logic       i_fade_req,
    output logic [4:0] o_level,
    output logic       o_busy,
    output logic       o_black
);
    localparam int              CNT_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [5:0]      STEP6  = 6'(FADE_STEP);
    localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_FRAMES);

    fade_state_e      r_state, w_state_next;
    logic [4:0]       r_level, w_level_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_busy, r_black;
    logic [5:0]       w_dec, w_inc;

    // Bit 5 of w_dec is the borrow: the step overshot zero.
    assign w_dec = {1'b0, r_level} - STEP6;
    assign w_inc = {1'b0, r_level} + STEP6;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_level <= LEVEL_MAX;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_black <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_state_next != IDLE);
            r_black <= (w_state_next == HOLD);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                w_level_next = LEVEL_MAX;
                if (i_fade_req) w_state_next = FADE_OUT;
            end
            FADE_OUT: begin
                if (i_frame_start) begin
                    w_level_next = w_dec[5] ? 5'd0 : w_dec[4:0];
                    if (w_dec[5] || (w_dec[4:0] == 5'd0)) begin
                        w_state_next = HOLD;
                        w_cnt_next   = '0;
                    end
                end
            end
            HOLD: begin
                if (i_frame_start) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_cnt_next == HOLD_N) w_state_next = FADE_IN;
                end
            end
            FADE_IN: begin
                if (i_frame_start) begin
                    if (w_inc >= {1'b0, LEVEL_MAX}) begin
                        w_level_next = LEVEL_MAX;
                        w_state_next = IDLE;
                    end else begin
                        w_level_next = w_inc[4:0];
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_level = w_level_next;
    assign o_busy  = r_busy;
    assign o_black = r_black;
endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: stage 1 registers sources, stage 2 picks the
// highest-priority visible colour, applies the fade level and drives the DAC.
module layer_compositor
    import vga_pkg::*;
#(
    parameter int      NUM_LAYERS  = 6,
    parameter int      NUM_OVL     = 2,
    parameter rgb565_t KEY_COLOR   = 16'hF81F,
    parameter int      FADE_STEP   = 2,
    parameter int      HOLD_FRAMES = 4
) (
    input logic              clk,
    input logic              reset_n,
    layer_compositor_if.slave bus
);
    logic                     r_de_s1;
    logic [NUM_LAYERS-1:0]    r_len_s1;
    logic [NUM_LAYERS*16-1:0] r_ldat_s1;
    logic [NUM_OVL-1:0]       r_oen_s1;
    logic [NUM_OVL*16-1:0]    r_ocol_s1;

    logic [3:0] r_red, r_green, r_blue;
    logic       r_de_out;

    logic [NUM_LAYERS-1:0] w_layer_vis;
    rgb565_t               w_pix;
    logic [4:0]            w_level;
    logic                  w_busy, w_black;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_vis
            assign w_layer_vis[gi] = r_len_s1[gi] && (r_ldat_s1[16*gi +: 16] != KEY_COLOR);
        end
    endgenerate

    // Scan from lowest priority up so the lowest index wins; overlays go last to outrank layers.
    always_comb begin
        w_pix = 16'h0000;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_layer_vis[i]) w_pix = r_ldat_s1[16*i +: 16];
        end
        for (int i = NUM_OVL - 1; i >= 0; i--) begin
            if (r_oen_s1[i]) w_pix = r_ocol_s1[16*i +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_de_s1   <= 1'b0;
            r_len_s1  <= '0;
            r_ldat_s1 <= '0;
            r_oen_s1  <= '0;
            r_ocol_s1 <= '0;
            r_red     <= 4'd0;
            r_green   <= 4'd0;
            r_blue    <= 4'd0;
            r_de_out  <= 1'b0;
        end else begin
            r_de_s1   <= bus.de_in;
            r_len_s1  <= bus.layer_en;
            r_ldat_s1 <= bus.layer_data;
            r_oen_s1  <= bus.ovl_en;
            r_ocol_s1 <= bus.ovl_color;
            r_de_out  <= r_de_s1;
            if (r_de_s1) begin
                r_red   <= scale4(w_pix[15:12], w_level);
                r_green <= scale4(w_pix[10:7],  w_level);
                r_blue  <= scale4(w_pix[4:1],   w_level);
            end else begin
                r_red   <= 4'd0;
                r_green <= 4'd0;
                r_blue  <= 4'd0;
            end
        end
    end

    fade_sequencer #(
        .FADE_STEP  (FADE_STEP),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) u_fade (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_frame_start(bus.frame_start),
        .i_fade_req   (bus.fade_req),
        .o_level      (w_level),
        .o_busy       (w_busy),
        .o_black      (w_black)
    );

    assign bus.red_port   = r_red;
    assign bus.green_port = r_green;
    assign bus.blue_port  = r_blue;
    assign bus.de_out     = r_de_out;
    assign bus.fade_busy  = w_busy;
    assign bus.fade_black = w_black;
endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed bench for layer_compositor against a frame-level
// reference model (priority pick, integer fade arithmetic, precomputed fade schedule).
module tb_layer_compositor;
    import vga_pkg::*;

    localparam int          NL   = 6;
    localparam int          NO   = 2;
    localparam int          STEP = 2;
    localparam int          HOLD = 4;
    localparam logic [15:0] KEY  = 16'hF81F;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    layer_compositor_if #(.NUM_LAYERS(NL), .NUM_OVL(NO)) bus ();

    layer_compositor #(
        .NUM_LAYERS(NL), .NUM_OVL(NO), .KEY_COLOR(KEY),
        .FADE_STEP(STEP), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Stimulus for the next cycle; pulses are cleared by step().
    logic              t_fs, t_fr, t_de;
    logic [NL-1:0]     t_len;
    logic [NL*16-1:0]  t_ldat;
    logic [NO-1:0]     t_oen;
    logic [NO*16-1:0]  t_ocol;

    // Reference model: pending per-frame levels of a running fade, and stage-1 contents.
    typedef struct packed {
        logic [4:0] level;
        logic       black;
    } sched_t;
    sched_t sched[$];
    int     m_level = 16;
    logic   m_black = 1'b0;
    logic              p_de;
    logic [NL-1:0]     p_len;
    logic [NL*16-1:0]  p_ldat;
    logic [NO-1:0]     p_oen;
    logic [NO*16-1:0]  p_ocol;

    task automatic build_sched();
        int     l;
        sched_t e;
        l = int'(LEVEL_MAX);
        sched.delete();
        while (l > 0) begin
            l = (l > STEP) ? l - STEP : 0;
            e.level = 5'(l); e.black = (l == 0);
            sched.push_back(e);
        end
        for (int i = 0; i < HOLD; i++) begin
            e.level = 5'd0; e.black = (i < HOLD - 1);
            sched.push_back(e);
        end
        while (l < 16) begin
            l = (l + STEP < 16) ? l + STEP : 16;
            e.level = 5'(l); e.black = 1'b0;
            sched.push_back(e);
        end
    endtask

    function automatic logic [11:0] ref_pixel(input logic de, input logic [NL-1:0] len,
            input logic [NL*16-1:0] ldat, input logic [NO-1:0] oen,
            input logic [NO*16-1:0] ocol, input int lvl);
        logic [15:0] c;
        bit          found;
        int          r, g, b;
        c = 16'h0000;
        found = 0;
        if (!de) return 12'h000;
        for (int i = 0; i < NO; i++)
            if (!found && oen[i]) begin c = ocol[16*i +: 16]; found = 1; end
        for (int i = 0; i < NL; i++)
            if (!found && len[i] && ldat[16*i +: 16] != KEY) begin c = ldat[16*i +: 16]; found = 1; end
        r = int'(c[15:12]) * lvl / 16;
        g = int'(c[10:7])  * lvl / 16;
        b = int'(c[4:1])   * lvl / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic step();
        logic [11:0] exp_rgb;
        logic        exp_de;
        sched_t      e;
        bus.frame_start = t_fs;
        bus.fade_req    = t_fr;
        bus.de_in       = t_de;
        bus.layer_en    = t_len;
        bus.layer_data  = t_ldat;
        bus.ovl_en      = t_oen;
        bus.ovl_color   = t_ocol;
        @(posedge clk);
        if (!reset_n) begin
            sched.delete();
            m_level = 16; m_black = 1'b0;
            exp_rgb = 12'h000; exp_de = 1'b0;
            p_de = 1'b0; p_len = '0; p_ldat = '0; p_oen = '0; p_ocol = '0;
        end else begin
            if (t_fs && sched.size() != 0) begin
                e = sched.pop_front();
                m_level = int'(e.level);
                m_black = e.black;
            end else if (t_fr && sched.size() == 0) begin
                build_sched();
            end
            exp_rgb = ref_pixel(p_de, p_len, p_ldat, p_oen, p_ocol, m_level);
            exp_de  = p_de;
            p_de = t_de; p_len = t_len; p_ldat = t_ldat; p_oen = t_oen; p_ocol = t_ocol;
        end
        #1;
        check("rgb", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'(exp_rgb));
        check("de_out", 32'(bus.de_out), 32'(exp_de));
        check("fade_busy", 32'(bus.fade_busy), 32'(sched.size() != 0));
        check("fade_black", 32'(bus.fade_black), 32'(m_black));
        t_fs = 1'b0;
        t_fr = 1'b0;
    endtask

    task automatic set_white();
        t_len  = 6'b100000;
        t_ldat = {16'hFFFF, 80'h0};
        t_oen  = '0;
        t_ocol = '0;
    endtask

    // Blanking cycle with frame_start, then a few active white pixels.
    task automatic frame();
        set_white();
        t_fs = 1'b1; t_de = 1'b0;
        step();
        t_de = 1'b1;
        repeat (3) step();
    endtask

    task automatic steady();
        repeat (2) step();
    endtask

    int red_out[8] = '{13, 11, 9, 7, 5, 3, 1, 0};
    int red_in[8]  = '{1, 3, 5, 7, 9, 11, 13, 15};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    initial begin
        t_fs = 0; t_fr = 0; t_de = 1;
        t_len = '1; t_ldat = '1; t_oen = 2'b11; t_ocol = '1;

        // Reset held with active inputs.
        reset_n = 1'b0;
        t_fr = 1'b1;
        step();
        step();
        check("reset_rgb", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'h0);
        check("reset_busy", 32'(bus.fade_busy), 32'h0);
        reset_n = 1'b1;
        set_white(); t_de = 1'b1;
        step();
        check("latency1_rgb", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'h0);
        step();
        check("latency2_rgb", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'hFFF);

        // Priority.
        t_len = 6'b000110; t_ldat = '0;
        t_ldat[31:16] = 16'h07E0; t_ldat[47:32] = 16'hF800;
        t_oen = '0; t_ocol = '0;
        steady();
        check("prio_layer1", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'h0F0);
        t_oen = 2'b10; t_ocol[31:16] = 16'h001F;
        steady();
        check("prio_ovl1", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'h00F);

        // Colour key.
        t_oen = '0; t_ldat[31:16] = KEY;
        steady();
        check("key_skip", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'hF00);
        t_len = 6'b000010;
        steady();
        check("all_keyed", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'h000);
        t_de = 1'b0; t_oen = 2'b11; t_ocol = '1;
        steady();
        check("de_low", 32'({bus.red_port, bus.green_port, bus.blue_port}), 32'h000);

        // Full fade sequence.
        set_white(); t_de = 1'b0; t_fr = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            frame();
            check("fade_out_red", 32'(bus.red_port), 32'(red_out[i]));
        end
        check("hold_black", 32'(bus.fade_black), 32'h1);
        for (int i = 0; i < HOLD; i++) begin
            frame();
            check("hold_black_n", 32'(bus.fade_black), 32'(i < HOLD - 1));
        end
        for (int i = 0; i < 8; i++) begin
            frame();
            check("fade_in_red", 32'(bus.red_port), 32'(red_in[i]));
        end
        check("fade_done_busy", 32'(bus.fade_busy), 32'h0);

        // fade_req coincident with frame_start, and fade_req during FADE_IN.
        set_white(); t_fs = 1'b1; t_fr = 1'b1; t_de = 1'b0;
        step();
        t_de = 1'b1;
        repeat (3) step();
        check("coincident_no_dec", 32'(bus.red_port), 32'hF);
        check("coincident_busy", 32'(bus.fade_busy), 32'h1);
        for (int i = 0; i < 8 + HOLD + 2; i++) frame();
        t_fr = 1'b1;
        step();
        for (int i = 2; i < 8; i++) begin
            frame();
            check("fade_in_ignore_req", 32'(bus.red_port), 32'(red_in[i]));
        end
        check("ignore_req_idle", 32'(bus.fade_busy), 32'h0);

        // Reset while in HOLD.
        t_fr = 1'b1; t_de = 1'b0;
        step();
        for (int i = 0; i < 10; i++) frame();
        check("in_hold_black", 32'(bus.fade_black), 32'h1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midreset_busy", 32'(bus.fade_busy), 32'h0);
        check("midreset_black", 32'(bus.fade_black), 32'h0);
        frame();
        check("midreset_full", 32'(bus.red_port), 32'hF);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            t_fs = ($urandom_range(0, 39) == 0);
            t_fr = ($urandom_range(0, 59) == 0);
            t_de = $urandom_range(0, 3) != 0;
            t_len = NL'($urandom);
            for (int i = 0; i < NL; i++)
                t_ldat[16*i +: 16] = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
            t_oen = ($urandom_range(0, 2) == 0) ? NO'($urandom) : '0;
            t_ocol = {16'($urandom), 16'($urandom)};
            reset_n = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
